// File: rtl/temp_scan_pkg.sv
// rtl/temp_scan_pkg.sv - shared FSM type, ADC command constants and width helper
//
// Imported by temp_sclk_gen and temp_scan_monitor.
package temp_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_NULL,
        ST_DATA,
        ST_CS_HOLD
    } state_t;

    // Leading bits of every ADC command word: start, single-ended.
    localparam logic START_BIT  = 1'b1;
    localparam logic SGL_BIT    = 1'b1;
    localparam int   NULL_SLOTS = 1;

    // A one-channel build still carries a 1-bit channel field.
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/temp_sclk_gen.sv
// rtl/temp_sclk_gen.sv - SCLK divider with rise/fall strobes for the ADC link
//
// Ports:
//   clk, rstc  clock, synchronous active-high reset
//   en         run the divider; when low sclk and the phase are held at 0
//   sclk       serial clock: low for the first SCLK_DIV cycles of a slot, high after
//   rise       one-cycle strobe on the edge where sclk goes 0->1
//   fall       one-cycle strobe on the edge that ends a slot (sclk 1->0)
module temp_sclk_gen #(
    parameter int SCLK_DIV = 4
) (
    input  logic clk,
    input  logic rstc,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int PH_W = $clog2(2 * SCLK_DIV);
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(SCLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_FALL = PH_W'(2 * SCLK_DIV - 1);

    logic [PH_W-1:0] phase;

    assign rise = en && (phase == PH_RISE);
    assign fall = en && (phase == PH_FALL);

    always_ff @(posedge clk) begin
        if (rstc || !en) begin
            phase <= '0;
            sclk  <= 1'b0;
        end else begin
            phase <= fall ? '0 : phase + 1'b1;
            if (rise) begin
                sclk <= 1'b1;
            end else if (fall) begin
                sclk <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/temp_scan_monitor.sv
// rtl/temp_scan_monitor.sv - round-robin serial-ADC temperature scanner with per-channel alarms
//
// Optional feature macro: TEMP_SCAN_HYST_EN (alarm hysteresis using thresh_lo).
//
// Ports:
//   clk, rstc             clock, synchronous active-high reset
//   en                    scanning runs while high
//   thresh_hi, thresh_lo  alarm set / clear thresholds (unsigned)
//   cs, sclk, din, dout   serial ADC link (cs active-low)
//   sample, sample_ch     last conversion result and its channel
//   sample_valid          one-cycle pulse when sample/sample_ch update
//   alarm                 per-channel over-temperature flags
//   busy                  high whenever the FSM is not idle
module temp_scan_monitor
    import temp_scan_pkg::*;
#(
    parameter int DATA_W   = 10,
    parameter int NUM_CH   = 2,
    parameter int SCLK_DIV = 4,
    parameter int CH_W     = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rstc,
    input  logic              en,
    input  logic [DATA_W-1:0] thresh_hi,
    input  logic [DATA_W-1:0] thresh_lo,
    output logic              cs,
    output logic              sclk,
    output logic              din,
    input  logic              dout,
    output logic [DATA_W-1:0] sample,
    output logic [CH_W-1:0]   sample_ch,
    output logic              sample_valid,
    output logic [NUM_CH-1:0] alarm,
    output logic              busy
);

    localparam int CMD_W  = CH_W + 2;
    localparam int SLOT_W = $clog2(DATA_W + CMD_W + 1);
    localparam int CNT_W  = $clog2(SCLK_DIV + 1);
    localparam logic [SLOT_W-1:0] CMD_LAST  = SLOT_W'(CMD_W - 1);
    localparam logic [SLOT_W-1:0] NULL_LAST = SLOT_W'(NULL_SLOTS - 1);
    localparam logic [SLOT_W-1:0] DATA_LAST = SLOT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCLK_DIV - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [SLOT_W-1:0] slot;
    logic [CH_W-1:0]   ch;
    logic [CMD_W-1:0]  cmd_word;
    logic [CMD_W-1:0]  cmd_sr;
    logic [DATA_W-1:0] data_sr;
    logic              sclk_run;
    logic              rise;
    logic              fall;

    assign cmd_word = {START_BIT, SGL_BIT, ch};
    assign sclk_run = state inside {ST_CMD, ST_NULL, ST_DATA};
    assign cs       = !(state inside {ST_CS_SETUP, ST_CMD, ST_NULL, ST_DATA});
    assign busy     = (state != ST_IDLE);

    temp_sclk_gen #(
        .SCLK_DIV(SCLK_DIV)
    ) u_sclk_gen (
        .clk (clk),
        .rstc(rstc),
        .en  (sclk_run),
        .sclk(sclk),
        .rise(rise),
        .fall(fall)
    );

    always_ff @(posedge clk) begin
        if (rstc) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (en)                         state_nx = ST_CS_SETUP;
            ST_CS_SETUP: if (cnt == CNT_LAST)            state_nx = ST_CMD;
            ST_CMD:      if (fall && slot == CMD_LAST)   state_nx = ST_NULL;
            ST_NULL:     if (fall && slot == NULL_LAST)  state_nx = ST_DATA;
            ST_DATA:     if (fall && slot == DATA_LAST)  state_nx = ST_CS_HOLD;
            ST_CS_HOLD:  if (cnt == CNT_LAST)            state_nx = ST_IDLE;
            default:                                     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstc) begin
            cnt          <= '0;
            slot         <= '0;
            ch           <= '0;
            cmd_sr       <= '0;
            data_sr      <= '0;
            din          <= 1'b0;
            sample       <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            alarm        <= '0;
        end else begin
            sample_valid <= 1'b0;

            // cnt times the cs setup/hold phases, slot counts bit slots; both restart per state.
            if (state_nx != state) begin
                cnt  <= '0;
                slot <= '0;
            end else begin
                cnt <= cnt + 1'b1;
                if (fall) begin
                    slot <= slot + 1'b1;
                end
            end

            case (state)
                ST_CS_SETUP: begin
                    // First command bit must already be on din when the first slot opens.
                    if (state_nx == ST_CMD) begin
                        din    <= cmd_word[CMD_W-1];
                        cmd_sr <= {cmd_word[CMD_W-2:0], 1'b0};
                    end
                end
                ST_CMD: begin
                    if (fall) begin
                        din    <= (state_nx == ST_CMD) ? cmd_sr[CMD_W-1] : 1'b0;
                        cmd_sr <= {cmd_sr[CMD_W-2:0], 1'b0};
                    end
                end
                ST_DATA: begin
                    if (rise) begin
                        data_sr <= {data_sr[DATA_W-2:0], dout};
                    end
                    if (state_nx == ST_CS_HOLD) begin
                        sample       <= data_sr;
                        sample_ch    <= ch;
                        sample_valid <= 1'b1;
`ifdef TEMP_SCAN_HYST_EN
                        if (data_sr > thresh_hi) begin
                            alarm[ch] <= 1'b1;
                        end else if (data_sr < thresh_lo) begin
                            alarm[ch] <= 1'b0;
                        end
`else
                        alarm[ch] <= (data_sr > thresh_hi);
`endif
                        ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef TEMP_SCAN_HYST_EN
    logic unused_thresh_lo;
    assign unused_thresh_lo = ^thresh_lo;
`endif

endmodule

// File: tb/tb_temp_scan_monitor.sv
// tb/tb_temp_scan_monitor.sv - scoreboard bench for temp_scan_monitor with a serial ADC model
module tb_temp_scan_monitor;

    localparam int DATA_W    = 10;
    localparam int NUM_CH    = 2;
    localparam int SCLK_DIV  = 4;
    localparam int CH_W      = 1;
    localparam int FRAME_LEN = SCLK_DIV + 2 * SCLK_DIV * (CH_W + 3 + DATA_W);
    localparam int GAP_LEN   = SCLK_DIV + 1;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] val;
        logic [NUM_CH-1:0] alarm;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstc = 1'b1;
    logic              en = 1'b0;
    logic [DATA_W-1:0] thresh_hi = 10'd37;
    logic [DATA_W-1:0] thresh_lo = 10'd35;
    logic              cs;
    logic              sclk;
    logic              din;
    logic              dout = 1'b0;
    logic [DATA_W-1:0] sample;
    logic [CH_W-1:0]   sample_ch;
    logic              sample_valid;
    logic [NUM_CH-1:0] alarm;
    logic              busy;

    always #5 clk = ~clk;

    temp_scan_monitor #(
        .DATA_W  (DATA_W),
        .NUM_CH  (NUM_CH),
        .SCLK_DIV(SCLK_DIV)
    ) dut (
        .clk         (clk),
        .rstc        (rstc),
        .en          (en),
        .thresh_hi   (thresh_hi),
        .thresh_lo   (thresh_lo),
        .cs          (cs),
        .sclk        (sclk),
        .din         (din),
        .dout        (dout),
        .sample      (sample),
        .sample_ch   (sample_ch),
        .sample_valid(sample_valid),
        .alarm       (alarm),
        .busy        (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ADC model: values to return per channel, consumed when a command is decoded.
    logic [DATA_W-1:0] vals0[$];
    logic [DATA_W-1:0] vals1[$];
    exp_t              sb_q[$];
    exp_t              sb_e;
    logic [NUM_CH-1:0] exp_alarm = '0;
    logic [CH_W-1:0]   exp_ch = '0;
    logic [CH_W+1:0]   cmd_bits = '0;
    logic [DATA_W-1:0] cur_val = '0;
    int                rise_n = 0;
    int                dj;

    always @(negedge cs) rise_n = 0;

    always @(posedge sclk) begin
        cmd_bits = {cmd_bits[CH_W:0], din};
        rise_n++;
        if (rise_n == CH_W + 2) begin
            check("cmd_bits", cmd_bits, {2'b11, exp_ch});
            if (exp_ch == 1'b0) cur_val = (vals0.size() > 0) ? vals0.pop_front() : 10'd1;
            else                cur_val = (vals1.size() > 0) ? vals1.pop_front() : 10'd1;
            if (cur_val > thresh_hi) exp_alarm[exp_ch] = 1'b1;
`ifdef TEMP_SCAN_HYST_EN
            else if (cur_val < thresh_lo) exp_alarm[exp_ch] = 1'b0;
`else
            else exp_alarm[exp_ch] = 1'b0;
`endif
            sb_e.ch    = exp_ch;
            sb_e.val   = cur_val;
            sb_e.alarm = exp_alarm;
            sb_q.push_back(sb_e);
            exp_ch = (exp_ch == CH_W'(NUM_CH - 1)) ? '0 : exp_ch + 1'b1;
        end
    end

    // Present the next data bit at the start of each slot (MSB first after the null slot).
    always @(negedge sclk) begin
        dj = rise_n - (CH_W + 3);
        dout = (dj >= 0 && dj < DATA_W) ? cur_val[DATA_W-1-dj] : 1'b0;
    end

    int n_valid = 0;
    int lo_cnt = 0;
    int hi_cnt = 0;
    bit gap_chk = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rstc) begin
            lo_cnt = 0;
            hi_cnt = 0;
        end else begin
            if (cs == 1'b0) begin
                if (hi_cnt > 0 && gap_chk) check("cs_gap", hi_cnt, GAP_LEN);
                hi_cnt = 0;
                lo_cnt++;
            end else begin
                if (lo_cnt > 0) check("frame_len", lo_cnt, FRAME_LEN);
                lo_cnt = 0;
                hi_cnt++;
            end
            if (sample_valid) begin
                n_valid++;
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", sample_valid, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sample", sample, mon_e.val);
                    check("sample_ch", sample_ch, mon_e.ch);
                    check("alarm", alarm, mon_e.alarm);
                end
            end
        end
    end

    task automatic wait_valids(input int target, input int budget);
        int k = 0;
        while (n_valid < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("valid_timeout", n_valid >= target, 1);
    endtask

    task automatic wait_cs_low(input int budget);
        int k = 0;
        while (cs !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("cs_fall_timeout", cs, 0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "cs"}, cs, 1);
        check({pfx, "sclk"}, sclk, 0);
        check({pfx, "din"}, din, 0);
        check({pfx, "sample"}, sample, 0);
        check({pfx, "sample_ch"}, sample_ch, 0);
        check({pfx, "sample_valid"}, sample_valid, 0);
        check({pfx, "alarm"}, alarm, 0);
        check({pfx, "busy"}, busy, 0);
    endtask

    initial begin
        vals0 = '{10'd37, 10'd38, 10'd40, 10'd36, 10'd34, 10'd100, 10'd44, 10'd50};
        vals1 = '{10'd10, 10'd600, 10'd10, 10'd10, 10'd10, 10'd20, 10'd5};

        repeat (3) @(negedge clk);
        check_reset_outputs("rst_");
        rstc = 1'b0;
        en   = 1'b1;

        // Continuous scan: ch0/ch1 alternate, gap between frames is minimal.
        wait_valids(1, 300);
        gap_chk = 1'b1;
        wait_valids(10, 12 * 130);

        // Drop en mid-frame: the frame still completes, then the link stays idle.
        wait_cs_low(50);
        repeat (30) @(negedge clk);
        gap_chk = 1'b0;
        en = 1'b0;
        wait_valids(11, 200);
        repeat (60) @(negedge clk);
        check("idle_cs", cs, 1);
        check("idle_busy", busy, 0);
        check("idle_sb_left", sb_q.size(), 0);
        check("idle_valids", n_valid, 11);

        // Resume: pointer was kept, so this frame targets ch1.
        en = 1'b1;
        wait_valids(12, 300);

        // Reset 50 cycles into the next frame: partial result dropped, pointer back to ch0.
        wait_cs_low(50);
        repeat (50) @(negedge clk);
        rstc = 1'b1;
        sb_q.delete();
        exp_alarm = '0;
        exp_ch    = '0;
        @(negedge clk);
        check_reset_outputs("rst_mid_");
        rstc = 1'b0;
        wait_valids(14, 400);
        en = 1'b0;
        repeat (150) @(negedge clk);
        check("end_busy", busy, 0);
        check("end_sb_left", sb_q.size(), 0);
        check("end_valids", n_valid, 14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/temp_scan_monitor.md
# temp_scan_monitor

Parametrised successor to the single-channel temperature sensor reader. Drives a serial ADC over a CS/SCLK/DIN/DOUT link and scans `NUM_CH` channels round-robin. Each result is compared against programmable high/low thresholds, and a per-channel alarm output is kept. Sits between the board-level ADC pins and the LED/alarm logic; replaces the fixed 10-bit, one-channel, LED-demux arrangement.

## Interface
Parameters:
- `DATA_W`, 10, ADC result width in bits.
- `NUM_CH`, 2, number of channels scanned (1..8).
- `SCLK_DIV`, 4, clk cycles per SCLK half-period (≥2).
- `CH_W`, max(1, clog2(`NUM_CH`)), channel index width (derived).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rstc`  in  1  reset, synchronous, active-high.
- `en`  in  1  level; scanning runs while high.
- `thresh_hi`  in  `DATA_W`  alarm set threshold (unsigned).
- `thresh_lo`  in  `DATA_W`  alarm clear threshold (used only with hysteresis).
- `cs`  out  1  ADC chip select, active-low.
- `sclk`  out  1  ADC serial clock.
- `din`  out  1  command bits to ADC.
- `dout`  in  1  data bits from ADC.
- `sample`  out  `DATA_W`  last conversion result.
- `sample_ch`  out  `CH_W`  channel of `sample`.
- `sample_valid`  out  1  one-cycle pulse when `sample`/`sample_ch` update.
- `alarm`  out  `NUM_CH`  per-channel over-temperature flag.
- `busy`  out  1  high while a frame is in progress (any state except IDLE).

## Operation
- Reset values: `cs`=1, `sclk`=0, `din`=0, `sample`=0, `sample_ch`=0, `sample_valid`=0, `alarm`=0, `busy`=0; channel pointer=0; FSM=IDLE.
- FSM states: IDLE → CS_SETUP → CMD → NULL → DATA → CS_HOLD → IDLE.
- IDLE: if `en`=1, go to CS_SETUP and drive `cs`=0.
- CS_SETUP: lasts `SCLK_DIV` cycles with `sclk`=0, then go to CMD.
- Bit slot: 2·`SCLK_DIV` cycles. `sclk`=0 for the first half and 1 for the second. `din` changes only at slot start.
- `dout` is sampled on the clk edge where `sclk` goes 0→1.
- CMD: shifts out MSB-first the word {start=1, single-ended=1, ch[`CH_W`-1:0]}, which is `CH_W`+2 slots.
- NULL: one slot, `din`=0, `dout` ignored.
- DATA: `DATA_W` slots; `dout` is shifted in MSB-first.
- CS_HOLD: entered after the last DATA slot.
  - `cs`=1 and `sclk`=0 for `SCLK_DIV` cycles.
  - On entry: `sample`←shift register, `sample_ch`←ch, `sample_valid`=1 for one cycle, alarm bit for ch updated.
  - Channel pointer advances; it wraps from `NUM_CH`-1 to 0.
- Leaving CS_HOLD: return to IDLE. If `en` is still 1, IDLE starts the next frame on the next cycle.
- `en` falling mid-frame: the frame completes normally, then the FSM stays in IDLE. The channel pointer is kept, so scanning resumes on the next channel.
- `rstc` mid-frame: all outputs take their reset values on the next edge. The partial result is discarded and no `sample_valid` is issued.
- Alarm compare is unsigned, full `DATA_W` width: set when `sample` > `thresh_hi` (strict).
- `NUM_CH`=1: `ch` is always 0, CMD still sends a 1-bit channel field (0).

## Timing
- Frame length, `cs` low to `cs` high: `SCLK_DIV` + 2·`SCLK_DIV`·(`CH_W`+3+`DATA_W`) cycles.
- Defaults: 4 + 8·14 = 116 cycles.
- `sample_valid` asserts on the first CS_HOLD cycle.
- `alarm` updates on the same edge as `sample` (zero added latency).
- Minimum `cs` high time between frames: `SCLK_DIV`+1 cycles.
- Thresholds are sampled at the CS_HOLD entry edge only. Changes at other times do not affect `alarm` until the next result.

## Configuration
- Macro: `TEMP_SCAN_HYST_EN`.
- Defined: hysteresis is active.
  - `alarm[ch]` sets when `sample` > `thresh_hi`.
  - `alarm[ch]` clears when `sample` < `thresh_lo`.
  - Otherwise `alarm[ch]` holds its value.
- Not defined: `thresh_lo` is unused, and `alarm[ch]` = (`sample` > `thresh_hi`), recomputed every conversion.

## Structure
- Package `temp_scan_pkg`:
  - FSM state enum.
  - Command constants: START_BIT=1, SGL_BIT=1, NULL_SLOTS=1.
  - Function computing `CH_W` from `NUM_CH`.
- Sub-module `temp_sclk_gen`: divider producing `sclk`, plus one-cycle `rise` and `fall` strobes. It is enabled only in CMD/NULL/DATA and is held at 0 otherwise.
- The FSM, shift registers and alarm compare live in the top module.

## Test plan
- Defaults, ADC model returns 10'h025 on ch0, `thresh_hi`=37 → one frame of 116 cycles, `sample`=37, `sample_ch`=0, `alarm`=2'b00.
- ADC model returns 38 on ch0 → `alarm[0]`=1 on the `sample_valid` cycle. ch1 returning 10 → `alarm[1]`=0.
- `NUM_CH`=4, `en` held high → `sample_ch` sequence 0,1,2,3,0. DIN command bits for ch2 are 1,1,1,0.
- With `TEMP_SCAN_HYST_EN`, `thresh_hi`=37, `thresh_lo`=35, ch0 values 40,36,34 → `alarm[0]` = 1,1,0. Without the macro the same values give 1,0,0.
- `en` dropped at cycle 30 of a frame → that frame completes with `sample_valid`, then `cs` stays 1 and `busy`=0.
- `rstc` at cycle 50 of a frame → next cycle `cs`=1 and `sclk`=0. No `sample_valid`, all outputs at reset values. The next frame targets ch0.
